// File: rtl/ulpi_tx_engine.sv
// ULPI transmit engine: sends TX CMD, payload bytes and STP on the PHY bus,
// honouring NXT throttling and backing off whenever the PHY takes the bus.
module ulpi_tx_engine #(
  parameter int NXT_TIMEOUT = 1023
) (
  input  logic       USB_CLKIN,
  input  logic       NRST,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_nodata,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_abort,
  input  logic       USB_DIR,
  input  logic       USB_NXT,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp
);

  localparam int CW = $clog2(NXT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NXT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CMD, DATA, STOP, ERR, WAIT_BUS} state_t;

  state_t        state, state_nxt;
  logic          dir_q;
  logic [3:0]    pid_q;
  logic          nodata_q;
  logic [CW-1:0] cnt;
  logic          bus_free;
  logic          accept;

  // dir_q covers the turnaround cycle after the PHY releases the bus
  assign bus_free     = !USB_DIR && !dir_q;
  assign accept       = (state == IDLE) && tx_start && bus_free;
  assign ulpi_data_oe = bus_free;
  assign tx_busy      = (state != IDLE);

  always_ff @(posedge USB_CLKIN or negedge NRST) begin
    if (!NRST) begin
      state    <= IDLE;
      dir_q    <= 1'b1;
      pid_q    <= 4'h0;
      nodata_q <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      dir_q <= USB_DIR;
      if (accept) begin
        pid_q    <= tx_pid;
        nodata_q <= tx_nodata;
      end
      if (state == CMD) cnt <= cnt + 1'b1;
      else              cnt <= '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    ulpi_data_o = 8'h00;
    ulpi_stp    = 1'b0;
    tx_ready    = 1'b0;
    tx_done     = 1'b0;
    tx_abort    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = CMD;
      end
      CMD: begin
        ulpi_data_o = {4'b0100, pid_q};
        if (USB_DIR) begin
          state_nxt = WAIT_BUS;
          tx_abort  = 1'b1;
        end else if (USB_NXT) begin
          state_nxt = nodata_q ? STOP : DATA;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ERR;
        end
      end
      DATA: begin
        ulpi_data_o = tx_data;
        if (USB_DIR) begin
          state_nxt = WAIT_BUS;
          tx_abort  = 1'b1;
        end else if (USB_NXT) begin
          tx_ready = 1'b1;
          // NXT with no byte available is an underrun
          if (!tx_valid)    state_nxt = ERR;
          else if (tx_last) state_nxt = STOP;
        end
      end
      STOP: begin
        ulpi_stp  = 1'b1;
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        ulpi_stp    = 1'b1;
        ulpi_data_o = 8'hFF;
        tx_abort    = 1'b1;
        state_nxt   = IDLE;
      end
      WAIT_BUS: begin
        if (bus_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ulpi_tx_engine.sv
// Bench for ulpi_tx_engine: expected bus bytes {stp,data} are queued as stimulus
// is driven and popped by a monitor whenever the engine owns the bus.
module tb_ulpi_tx_engine;

  logic       clk = 1'b0;
  logic       nrst;
  logic       tx_start, tx_nodata, tx_valid, tx_last;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_busy, tx_done, tx_abort;
  logic       usb_dir, usb_nxt;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe, ulpi_stp;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int ready_cnt = 0;
  logic overlap = 1'b0;
  logic [8:0] exp_q[$];

  ulpi_tx_engine dut (
    .USB_CLKIN(clk), .NRST(nrst),
    .tx_start(tx_start), .tx_pid(tx_pid), .tx_nodata(tx_nodata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_abort(tx_abort),
    .USB_DIR(usb_dir), .USB_NXT(usb_nxt),
    .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every driven bus cycle of an active packet pops one entry
  always @(negedge clk) begin
    logic [8:0] e;
    if (nrst) begin
      if (tx_done)  done_cnt++;
      if (tx_abort) abort_cnt++;
      if (tx_ready) ready_cnt++;
      if (tx_done && tx_abort) overlap = 1'b1;
      if (tx_busy && ulpi_data_oe) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL bus_extra: got stp/data %b/%h, expected nothing", ulpi_stp, ulpi_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({ulpi_stp, ulpi_data_o} !== e) begin
            mismatched++;
            $display("[TB] FAIL bus_byte: got stp/data %b/%h, expected %b/%h",
                     ulpi_stp, ulpi_data_o, e[8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_start = 1'b0; tx_nodata = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    tx_pid = 4'h0; tx_data = 8'h00; usb_nxt = 1'b0; usb_dir = 1'b0;
  endtask

  task automatic check_end(input string name, input int d0, input int a0,
                           input int exp_d, input int exp_a);
    compared++;
    if (tx_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_idle: busy=%b, expected 0", name, tx_busy);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_queue: %0d bus bytes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    compared++;
    if (done_cnt - d0 != exp_d || abort_cnt - a0 != exp_a) begin
      mismatched++;
      $display("[TB] FAIL %s_pulses: done=%0d abort=%0d, expected done=%0d abort=%0d",
               name, done_cnt - d0, abort_cnt - a0, exp_d, exp_a);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1'b0;
    repeat (2) cycle();
    compared++;
    if ({ulpi_data_o, ulpi_data_oe, ulpi_stp, tx_ready, tx_busy, tx_done, tx_abort} !== 14'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got data=%h oe=%b stp=%b rdy=%b busy=%b done=%b abort=%b, expected all 0",
               ulpi_data_o, ulpi_data_oe, ulpi_stp, tx_ready, tx_busy, tx_done, tx_abort);
    end
    nrst = 1'b1;
    tx_start = 1'b1; tx_pid = 4'h5;
    @(negedge clk);
    compared++;
    if (ulpi_data_oe !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_turnaround_oe: got %b, expected 0", ulpi_data_oe);
    end
    cycle();
    tx_start = 1'b0;
    compared++;
    if (tx_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_start_ignored: busy=%b, expected 0", tx_busy);
    end
    compared++;
    if (ulpi_data_oe !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_oe_after: got %b, expected 1", ulpi_data_oe);
    end
  endtask

  task automatic test_handshake();
    int d0 = done_cnt, a0 = abort_cnt;
    exp_q.push_back({1'b0, 8'h42});
    exp_q.push_back({1'b0, 8'h42});
    exp_q.push_back({1'b1, 8'h00});
    tx_start = 1'b1; tx_pid = 4'h2; tx_nodata = 1'b1;
    cycle(); tx_start = 1'b0; usb_nxt = 1'b0;
    cycle(); usb_nxt = 1'b1;
    cycle(); usb_nxt = 1'b0;
    @(negedge clk);
    compared++;
    if (tx_done !== 1'b1 || ulpi_stp !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hs_stop: done=%b stp=%b, expected 1/1", tx_done, ulpi_stp);
    end
    cycle();
    check_end("hs", d0, a0, 1, 0);
  endtask

  task automatic test_data_packet();
    int d0 = done_cnt, a0 = abort_cnt, r0 = ready_cnt;
    exp_q.push_back({1'b0, 8'h43});
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b0, 8'hB2});
    exp_q.push_back({1'b0, 8'hB2});
    exp_q.push_back({1'b0, 8'hC3});
    exp_q.push_back({1'b1, 8'h00});
    tx_start = 1'b1; tx_pid = 4'h3; tx_nodata = 1'b0;
    cycle(); tx_start = 1'b0; usb_nxt = 1'b1;
    cycle(); tx_data = 8'hA1; tx_valid = 1'b1;
    cycle(); tx_data = 8'hB2; usb_nxt = 1'b0;
    cycle(); usb_nxt = 1'b1;
    cycle(); tx_data = 8'hC3; tx_last = 1'b1;
    cycle(); tx_valid = 1'b0; tx_last = 1'b0; usb_nxt = 1'b0; tx_data = 8'h00;
    @(negedge clk);
    compared++;
    if (tx_done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL data_done: got %b, expected 1", tx_done);
    end
    cycle();
    check_end("data", d0, a0, 1, 0);
    compared++;
    if (ready_cnt - r0 != 3) begin
      mismatched++;
      $display("[TB] FAIL data_ready_beats: got %0d, expected 3", ready_cnt - r0);
    end
  endtask

  task automatic test_underrun();
    int d0 = done_cnt, a0 = abort_cnt;
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'hFF});
    tx_start = 1'b1; tx_pid = 4'h1; tx_nodata = 1'b0;
    cycle(); tx_start = 1'b0; usb_nxt = 1'b1;
    cycle(); tx_data = 8'hD5; tx_valid = 1'b1;
    cycle(); tx_data = 8'h00; tx_valid = 1'b0;
    cycle(); usb_nxt = 1'b0;
    @(negedge clk);
    compared++;
    if (tx_abort !== 1'b1 || tx_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL underrun_err: abort=%b done=%b, expected 1/0", tx_abort, tx_done);
    end
    cycle();
    check_end("underrun", d0, a0, 0, 1);
  endtask

  task automatic test_dir_preempt();
    int d0 = done_cnt, a0 = abort_cnt;
    exp_q.push_back({1'b0, 8'h44});
    exp_q.push_back({1'b0, 8'h11});
    tx_start = 1'b1; tx_pid = 4'h4; tx_nodata = 1'b0;
    cycle(); tx_start = 1'b0; usb_nxt = 1'b1;
    cycle(); tx_data = 8'h11; tx_valid = 1'b1;
    cycle(); tx_data = 8'h22; usb_dir = 1'b1;
    @(negedge clk);
    compared++;
    if (ulpi_data_oe !== 1'b0 || tx_abort !== 1'b1 || tx_ready !== 1'b0 || ulpi_stp !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dir_preempt: oe=%b abort=%b rdy=%b stp=%b, expected 0/1/0/0",
               ulpi_data_oe, tx_abort, tx_ready, ulpi_stp);
    end
    cycle(); tx_valid = 1'b0; usb_nxt = 1'b0;
    compared++;
    if (tx_busy !== 1'b1 || tx_abort !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dir_waitbus: busy=%b abort=%b, expected 1/0", tx_busy, tx_abort);
    end
    cycle(); usb_dir = 1'b0;
    compared++;
    if (ulpi_data_oe !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dir_turnaround_oe: got %b, expected 0", ulpi_data_oe);
    end
    exp_q.push_back({1'b0, 8'h00});
    cycle();
    cycle(); tx_start = 1'b1; tx_pid = 4'h6; tx_nodata = 1'b1;
    compared++;
    if (tx_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dir_back_idle: busy=%b, expected 0", tx_busy);
    end
    exp_q.push_back({1'b0, 8'h46});
    exp_q.push_back({1'b1, 8'h00});
    cycle(); tx_start = 1'b0; usb_nxt = 1'b1;
    compared++;
    if (tx_busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL dir_restart: busy=%b, expected 1", tx_busy);
    end
    cycle(); usb_nxt = 1'b0;
    cycle();
    check_end("dir", d0, a0, 1, 1);
  endtask

  task automatic test_timeout_and_reset();
    int d0 = done_cnt, a0 = abort_cnt;
    for (int i = 0; i < 1023; i++) exp_q.push_back({1'b0, 8'h47});
    exp_q.push_back({1'b1, 8'hFF});
    tx_start = 1'b1; tx_pid = 4'h7; tx_nodata = 1'b0;
    cycle(); tx_start = 1'b0; usb_nxt = 1'b0;
    repeat (1023) cycle();
    @(negedge clk);
    compared++;
    if (tx_abort !== 1'b1 || ulpi_stp !== 1'b1 || ulpi_data_o !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL timeout_err: abort=%b stp=%b data=%h, expected 1/1/ff",
               tx_abort, ulpi_stp, ulpi_data_o);
    end
    cycle();
    check_end("timeout", d0, a0, 0, 1);

    d0 = done_cnt; a0 = abort_cnt;
    exp_q.push_back({1'b0, 8'h48});
    exp_q.push_back({1'b0, 8'h5A});
    tx_start = 1'b1; tx_pid = 4'h8;
    cycle(); tx_start = 1'b0; usb_nxt = 1'b1;
    cycle(); tx_data = 8'h5A; tx_valid = 1'b1;
    cycle(); tx_data = 8'h6B; nrst = 1'b0;
    #2;
    compared++;
    if ({ulpi_data_o, ulpi_data_oe, ulpi_stp, tx_ready, tx_busy, tx_done, tx_abort} !== 14'h0) begin
      mismatched++;
      $display("[TB] FAIL midpkt_reset: got data=%h oe=%b stp=%b rdy=%b busy=%b done=%b abort=%b, expected all 0",
               ulpi_data_o, ulpi_data_oe, ulpi_stp, tx_ready, tx_busy, tx_done, tx_abort);
    end
    cycle(); idle_inputs(); nrst = 1'b1;
    cycle();
    cycle();
    check_end("midreset", d0, a0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_data_packet();
    test_underrun();
    test_dir_preempt();
    test_timeout_and_reset();
    compared++;
    if (overlap !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL done_abort_overlap: got %b, expected 0", overlap);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
